// File: rtl/qupls_rb_encode_trace.sv
// Commit-side re-encoder: architectural register numbers back to instruction register fields, buffered for the trace port.
// Optional stale-alias mode check enabled by defining QUPLS_RBENC_MODECHK_EN.
module qupls_rb_encode_trace #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            in_v,
    input  logic [1:0]      in_om,
    input  logic [8:0]      in_areg,
    output logic            out_v,
    input  logic            out_rdy,
    output logic [5:0]      out_fld,
    output logic            out_regx,
    output logic            out_sp,
    output logic [1:0]      out_om,
    output logic            out_err,
    output logic            full,
    output logic [CNTW-1:0] drops
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic       err;
        logic [1:0] om;
        logic       sp;
        logic       regx;
        logic [5:0] fld;
    } rec_t;

    rec_t          enc;
    rec_t          cap_rec;
    logic          cap_v;
    rec_t          mem [DEPTH];
    rec_t          head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

    // SP alias (65..68) takes priority over the extended-bank x1..x4 encoding
    always_comb begin
        enc      = '0;
        enc.om   = in_om;
        enc.fld  = in_areg[5:0];
        if (in_areg >= 9'd65 && in_areg <= 9'd68) begin
            enc.fld = 6'd63;
            enc.sp  = 1'b1;
            enc.om  = in_areg[1:0] - 2'd1;
`ifdef QUPLS_RBENC_MODECHK_EN
            enc.err = (enc.om != in_om);
`endif
        end else if (in_areg <= 9'd62) begin
            enc.regx = 1'b0;
        end else if (in_areg == 9'd63) begin
            enc.err = 1'b1;
        end else if (in_areg <= 9'd127) begin
            enc.regx = 1'b1;
        end else begin
            enc.err  = 1'b1;
            enc.regx = in_areg[6];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_v   <= 1'b0;
            cap_rec <= '0;
        end else begin
            cap_v   <= in_v;
            cap_rec <= enc;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_v = !empty;
    assign pop   = out_v && out_rdy;
    assign push  = cap_v && (!full || pop);
    assign drop  = cap_v && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drops  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop && drops != {CNTW{1'b1}})
                drops <= drops + CNTW'(1);
        end
    end

    // Storage needs no reset: contents are invisible while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= cap_rec;
    end

    assign head     = out_v ? mem[rd_ptr[AW-1:0]] : '0;
    assign out_fld  = head.fld;
    assign out_regx = head.regx;
    assign out_sp   = head.sp;
    assign out_om   = head.om;
    assign out_err  = head.err;

endmodule
